// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_ctrl
// Purpose  : Reset sequencer for a multi-clock-domain design. It releases one
//            active-low reset per domain in ascending order. Before it releases
//            the next domain, it waits for the current domain's (synchronized)
//            acknowledge plus a programmable gap. A software request restarts
//            the whole sequence.
// Ports    : CLK         - sequencer clock
//            RST         - asynchronous active-low reset
//            SW_RST_REQ  - synchronous software re-sequence request (level)
//            DOM_ACK     - per-domain "reset released" status (async to CLK)
//            DOM_RST_N   - per-domain active-low reset outputs
//            SEQ_DONE    - all domains released
//            BUSY        - sequencing in progress (HOLD / WAIT_ACK / GAP)
//            ERR         - sticky acknowledge-timeout flag
// Options  : RST_SEQ_TIMEOUT_EN - when defined, an acknowledge that does not
//            arrive within ACK_TIMEOUT cycles drops every domain back into
//            reset and parks the sequencer in FAIL with ERR set.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOM_ACK,
    output logic [NUM_DOMAINS-1:0] DOM_RST_N,
    output logic                   SEQ_DONE,
    output logic                   BUSY,
    output logic                   ERR
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0]     C_LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [CNT_WIDTH-1:0] C_HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] C_ACK_LAST  = CNT_WIDTH'(ACK_TIMEOUT - 1);
`endif
    localparam int C_CNT_NEED_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int C_CNT_NEED    = (C_CNT_NEED_HG > ACK_TIMEOUT) ? C_CNT_NEED_HG : ACK_TIMEOUT;

    // Elaboration-time sanity check of the configuration.
    generate
        if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || ACK_TIMEOUT < 1 ||
            (CNT_WIDTH < 31 && C_CNT_NEED > (1 << CNT_WIDTH))) begin : g_param_check
            $error("rst_seq_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_GAP      = 3'd2,
        ST_DONE     = 3'd3
`ifdef RST_SEQ_TIMEOUT_EN
        , ST_FAIL   = 3'd4
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
`ifdef RST_SEQ_TIMEOUT_EN
    logic                   err_q, err_d;
`endif
    logic [NUM_DOMAINS-1:0] ack_meta_q, ack_sync_q;
    logic                   ack_cur;

    // Two-flop synchronizer per acknowledge bit; only ack_sync_q is used.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_meta_q <= '0;
            ack_sync_q <= '0;
        end else begin
            ack_meta_q <= DOM_ACK;
            ack_sync_q <= ack_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef RST_SEQ_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
`ifdef RST_SEQ_TIMEOUT_EN
        err_d   = err_q;
`endif
        ack_cur = ack_sync_q[idx_q];

        if (SW_RST_REQ) begin
            // Software restart wins over every other transition.
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_n_d = '0;
`ifdef RST_SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == C_HOLD_LAST) begin
                        rst_n_d[idx_q] = 1'b1;
                        state_d        = ST_WAIT_ACK;
                        cnt_d          = '0;
                    end
                end
                ST_WAIT_ACK: begin
                    // An acknowledge on the timeout edge takes precedence.
                    if (ack_cur) begin
                        state_d = (idx_q == C_LAST_IDX) ? ST_DONE : ST_GAP;
                        cnt_d   = '0;
                    end
`ifdef RST_SEQ_TIMEOUT_EN
                    else if (cnt_q == C_ACK_LAST) begin
                        state_d = ST_FAIL;
                        rst_n_d = '0;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end
`endif
                end
                ST_GAP: begin
                    if (cnt_q == C_GAP_LAST) begin
                        idx_d          = idx_q + 1'b1;
                        rst_n_d[idx_d] = 1'b1;
                        state_d        = ST_WAIT_ACK;
                        cnt_d          = '0;
                    end
                end
                ST_DONE: begin
                    // Parked; later acknowledge changes are ignored.
                    cnt_d = cnt_q;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                ST_FAIL: begin
                    cnt_d = cnt_q;
                end
`endif
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        // Status outputs are registered from the next state.
        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_HOLD) || (state_d == ST_WAIT_ACK) || (state_d == ST_GAP);
    end

    assign DOM_RST_N = rst_n_q;
    assign SEQ_DONE  = done_q;
    assign BUSY      = busy_q;
`ifdef RST_SEQ_TIMEOUT_EN
    assign ERR       = err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for a multi-clock-domain design. It releases one active-low reset per clock domain in a fixed order: domain 0 first, then domain 1, and so on. Each domain resynchronises its reset locally with its own reset synchronizer and returns a "released" acknowledge. The sequencer waits for that acknowledge plus a programmable gap before it releases the next domain. Software can request a full re-sequence at any time.

Parameters:
- NUM_DOMAINS, 3, number of reset domains sequenced (>=1).
- HOLD_CYCLES, 16, CLK cycles all domains stay in reset after RST deasserts (>=1).
- GAP_CYCLES, 8, CLK cycles between an acknowledge and the release of the next domain (>=1).
- ACK_TIMEOUT, 64, CLK cycles allowed for an acknowledge (used only with the optional feature).
- CNT_WIDTH, 8, width of the shared cycle counter; must hold max(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT).

Ports:
- CLK  in  1  sequencer clock.
- RST  in  1  asynchronous, active-low reset.
- SW_RST_REQ  in  1  synchronous request for a software reset; level, sampled each CLK edge.
- DOM_ACK  in  NUM_DOMAINS  per-domain "reset released" status from the domain side; asynchronous to CLK.
- DOM_RST_N  out  NUM_DOMAINS  per-domain active-low reset, fed to each domain's reset synchronizer.
- SEQ_DONE  out  1  high when all domains are released.
- BUSY  out  1  high while sequencing (states HOLD, WAIT_ACK, GAP).
- ERR  out  1  sticky acknowledge-timeout flag.

Behaviour:
- Reset (RST=0) values:
  - DOM_RST_N = all 0; SEQ_DONE = 0; BUSY = 1; ERR = 0.
  - state = HOLD; counter = 0; domain index idx = 0.
  - DOM_ACK synchronizer flops = 0.
- DOM_ACK synchronisation: each bit passes through an internal 2-flop synchronizer; ackS[i] is the synchronized value. All decisions use ackS only.
- All outputs are registered. The counter clears to 0 on every state entry and increments once per edge inside the state.
- States and transitions:
  - HOLD: on the edge where counter == HOLD_CYCLES-1, set DOM_RST_N[idx]=1 and go to WAIT_ACK.
  - WAIT_ACK: on the first edge with ackS[idx]=1:
    - if idx == NUM_DOMAINS-1, go to DONE;
    - otherwise go to GAP.
  - GAP: on the edge where counter == GAP_CYCLES-1, increment idx, set DOM_RST_N[idx]=1, and go to WAIT_ACK.
  - DONE: SEQ_DONE=1, BUSY=0. Stays here until RST or SW_RST_REQ. A later drop of ackS is ignored.
  - FAIL: exists only with the optional feature.
- Released domains stay released; DOM_RST_N bits only ever go 0->1 during a sequence.
- SW_RST_REQ=1 on an edge, in any state:
  - next values: DOM_RST_N = 0, SEQ_DONE = 0, ERR = 0, idx = 0, counter = 0, state = HOLD;
  - it has priority over every other transition on the same edge;
  - holding it high keeps the block in HOLD with counter = 0.
- Asynchronous RST assertion mid-sequence immediately forces all DOM_RST_N low, regardless of the CLK phase.
- NUM_DOMAINS=1: HOLD -> WAIT_ACK -> DONE; GAP is never entered.

Optional Feature:
- Macro: RST_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_ACK, if counter reaches ACK_TIMEOUT-1 with ackS[idx]=0, the next edge sets ERR=1 and DOM_RST_N=0 and enters FAIL.
  - In FAIL: BUSY=0, SEQ_DONE=0. Only SW_RST_REQ or RST leave it.
  - If the acknowledge arrives on the same edge as the timeout, the acknowledge wins.
- Not defined: WAIT_ACK waits indefinitely; ERR is constant 0; FAIL state and ACK_TIMEOUT comparison logic are absent.

Test Plan:
All scenarios use defaults (3 domains, HOLD 16, GAP 8). Edges are counted from RST deassertion.
- DOM_ACK tied 3'b111 -> DOM_RST_N[0] rises at edge 16, [1] at edge 25, [2] at edge 34; SEQ_DONE=1 and BUSY=0 after edge 35.
- DOM_ACK[1] driven high 20 cycles after DOM_RST_N[1] rises -> DOM_RST_N[2] stays 0 until 8 edges after the synchronized acknowledge; no early release.
- SW_RST_REQ pulsed for 1 cycle in DONE -> all DOM_RST_N=0 and SEQ_DONE=0 next edge; the full sequence repeats with the same edge offsets measured from the pulse.
- RST asserted while in GAP after domain 0 is released -> DOM_RST_N=0 immediately (asynchronously); the sequence restarts at domain 0 after RST deasserts.
- RST_SEQ_TIMEOUT_EN, DOM_ACK[0] held 0 -> ERR=1 and state FAIL at edge 80 with DOM_RST_N=0; SW_RST_REQ clears ERR.
- RST_SEQ_TIMEOUT_EN, acknowledge arriving on the same edge as the timeout -> no ERR, sequence continues to GAP.
